// File: rtl/vid_pkg.sv
// Shared types and helpers for the internal video timing / test-pattern source.
package vid_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SEG_SYNC = 2'd0,
        SEG_BP   = 2'd1,
        SEG_ACT  = 2'd2,
        SEG_FP   = 2'd3
    } seg_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int unsigned seg_total(input int unsigned sync,
                                              input int unsigned bp,
                                              input int unsigned act,
                                              input int unsigned fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/vin_pattern_gen_if.sv
// Video output bundle: syncs, data-enable and one pixel group per clock.
interface vin_pattern_gen_if #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned PPC   = 1
);
    logic                   v_vsync;
    logic                   v_hsync;
    logic                   v_de;
    logic [PIX_W*PPC-1:0]   v_pixel;

    modport master (output v_vsync, v_hsync, v_de, v_pixel);
    modport slave  (input  v_vsync, v_hsync, v_de, v_pixel);
endinterface

// File: rtl/vid_axis_counter.sv
// One timing axis (line or frame): position counter, segment decode and wrap strobe.
module vid_axis_counter import vid_pkg::*; #(
    parameter int unsigned SYNC = 2,
    parameter int unsigned BP   = 2,
    parameter int unsigned ACT  = 4,
    parameter int unsigned FP   = 2,
    localparam int unsigned TOT = seg_total(SYNC, BP, ACT, FP),
    localparam int unsigned W   = $clog2(TOT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output seg_e         seg,
    output logic         wrap
);

    assign wrap = inc && (cnt == W'(TOT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (wrap)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + W'(1);
    end

    always_comb begin
        if (cnt < W'(SYNC))
            seg = SEG_SYNC;
        else if (cnt < W'(SYNC + BP))
            seg = SEG_BP;
        else if (cnt < W'(SYNC + BP + ACT))
            seg = SEG_ACT;
        else
            seg = SEG_FP;
    end

endmodule

// File: rtl/vin_pattern_gen.sv
// Programmable video timing generator with selectable test patterns, PPC pixels per clock.
//   state   | meaning
//   ST_IDLE | counters parked at 0, all outputs inactive, waiting for en
//   ST_RUN  | counters advancing; en is only re-examined at the frame wrap
module vin_pattern_gen import vid_pkg::*; #(
    parameter int unsigned H_FP      = 32,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 152,
    parameter int unsigned H_ACT     = 800,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 3,
    parameter int unsigned V_BP      = 46,
    parameter int unsigned V_ACT     = 1200,
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned PPC       = 1,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned BAR_SHIFT = 7,
    parameter int unsigned CHK_SHIFT = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    vin_pattern_gen_if.master        vid,
    output logic                     frame_start,
    output logic [15:0]              frame_cnt,
    output logic                     busy
);

    localparam int unsigned H_TOT = seg_total(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int unsigned V_TOT = seg_total(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int unsigned HW    = $clog2(H_TOT);
    localparam int unsigned VW    = $clog2(V_TOT);
    // x is kept only as wide as the highest bit any pattern looks at; the
    // dropped upper bits cannot influence a pattern, so the result is exact.
    localparam int unsigned XW0   = (PIX_W > BAR_SHIFT + 3) ? PIX_W : BAR_SHIFT + 3;
    localparam int unsigned XW    = (XW0 > CHK_SHIFT + 1) ? XW0 : CHK_SHIFT + 1;
    localparam int unsigned YW    = (VW > CHK_SHIFT + 1) ? VW : CHK_SHIFT + 1;

    state_e               state;
    state_e               state_nxt;
    logic                 run;
    logic [HW-1:0]        hcnt;
    logic [VW-1:0]        vcnt;
    seg_e                 h_seg;
    seg_e                 v_seg;
    logic                 h_wrap;
    logic                 v_wrap;
    mode_e                mode_q;
    logic [XW-1:0]        x_base;
    logic                 y_chk;
    wire  [PIX_W*PPC-1:0] pix_nxt;
    logic                 hs_nxt;
    logic                 vs_nxt;
    logic                 de_nxt;
    logic                 fs_nxt;

    assign run = (state == ST_RUN);

    vid_axis_counter #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP)
    ) u_hcnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (run),
        .cnt  (hcnt),
        .seg  (h_seg),
        .wrap (h_wrap)
    );

    vid_axis_counter #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP)
    ) u_vcnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (h_wrap),
        .cnt  (vcnt),
        .seg  (v_seg),
        .wrap (v_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en)              state_nxt = ST_RUN;
            ST_RUN:  if (v_wrap && !en)   state_nxt = ST_IDLE;
            default:                      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hs_nxt = 1'b0;
        vs_nxt = 1'b0;
        de_nxt = 1'b0;
        fs_nxt = 1'b0;
        if (run) begin
            hs_nxt = (h_seg == SEG_SYNC);
            vs_nxt = (v_seg == SEG_SYNC);
            de_nxt = (h_seg == SEG_ACT) && (v_seg == SEG_ACT);
            fs_nxt = (hcnt == '0) && (vcnt == '0);
        end
    end

    assign x_base = XW'(hcnt - HW'(H_SYNC + H_BP)) * XW'(PPC);
    assign y_chk  = 1'((YW'(vcnt) - YW'(V_SYNC + V_BP)) >> CHK_SHIFT);

    for (genvar l = 0; l < PPC; l++) begin : g_lane
        logic [XW-1:0]    x;
        logic [PIX_W-1:0] lane_pix;

        assign x = x_base + XW'(l);

        always_comb begin
            lane_pix = '0;
            case (mode_q)
                MODE_SOLID: lane_pix = PIX_W'(1) << (PIX_W - 1);
                MODE_GRAD:  lane_pix = x[PIX_W-1:0];
                MODE_BARS:  lane_pix = PIX_W'(x[BAR_SHIFT +: 3]) << (PIX_W - 3);
                MODE_CHECK: lane_pix = {PIX_W{x[CHK_SHIFT] ^ y_chk}};
                default:    lane_pix = '0;
            endcase
        end

        assign pix_nxt[l*PIX_W +: PIX_W] = lane_pix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vid.v_hsync <= ~HS_POL;
            vid.v_vsync <= ~VS_POL;
            vid.v_de    <= 1'b0;
            vid.v_pixel <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            mode_q      <= MODE_SOLID;
        end else begin
            vid.v_hsync <= hs_nxt ? HS_POL : ~HS_POL;
            vid.v_vsync <= vs_nxt ? VS_POL : ~VS_POL;
            vid.v_de    <= de_nxt;
            vid.v_pixel <= de_nxt ? pix_nxt : '0;
            frame_start <= fs_nxt;
            busy        <= run;
            // pattern choice is latched only at the top of a frame
            if (fs_nxt) begin
                frame_cnt <= frame_cnt + 16'd1;
                mode_q    <= mode_e'(mode);
            end
        end
    end

endmodule

// File: tb/tb_vin_pattern_gen.sv
// Scoreboard bench: three small-timing instances, pixel queues drained by per-DUT monitors.
module tb_vin_pattern_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // DUT A: H 2/2/4/2 (sync/bp/act/fp), V 1/1/3/1, PPC=1, BAR_SHIFT=1
    logic        rst_a, en_a, fs_a, busy_a;
    logic [1:0]  mode_a;
    logic [15:0] cnt_a;
    vin_pattern_gen_if #(.PIX_W(8), .PPC(1)) vif_a ();
    vin_pattern_gen #(
        .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(4),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(3),
        .PIX_W(8), .PPC(1), .HS_POL(1'b1), .VS_POL(1'b1),
        .BAR_SHIFT(1), .CHK_SHIFT(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .vid(vif_a),
        .frame_start(fs_a), .frame_cnt(cnt_a), .busy(busy_a)
    );

    // DUT B: same timing, PPC=2, active-low syncs
    logic        rst_bc, en_b, fs_b, busy_b;
    logic [1:0]  mode_b;
    logic [15:0] cnt_b;
    vin_pattern_gen_if #(.PIX_W(8), .PPC(2)) vif_b ();
    vin_pattern_gen #(
        .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(4),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(3),
        .PIX_W(8), .PPC(2), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst_bc), .en(en_b), .mode(mode_b), .vid(vif_b),
        .frame_start(fs_b), .frame_cnt(cnt_b), .busy(busy_b)
    );

    // DUT C: 4x4 active area, checker cells of 2
    logic        en_c, fs_c, busy_c;
    logic [1:0]  mode_c;
    logic [15:0] cnt_c;
    vin_pattern_gen_if #(.PIX_W(8), .PPC(1)) vif_c ();
    vin_pattern_gen #(
        .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(4),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4),
        .PIX_W(8), .PPC(1), .HS_POL(1'b1), .VS_POL(1'b1),
        .BAR_SHIFT(1), .CHK_SHIFT(1)
    ) dut_c (
        .clk(clk), .rst(rst_bc), .en(en_c), .mode(mode_c), .vid(vif_c),
        .frame_start(fs_c), .frame_cnt(cnt_c), .busy(busy_c)
    );

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [15:0] q_c[$];

    always @(negedge clk) begin
        if (vif_a.v_de === 1'b1) begin
            chk("a_pix_avail", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) chk("a_pix", 32'(vif_a.v_pixel), 32'(q_a.pop_front()));
        end else
            chk("a_pix_blank", 32'(vif_a.v_pixel), 32'd0);
    end

    always @(negedge clk) begin
        if (vif_b.v_de === 1'b1) begin
            chk("b_pix_avail", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) chk("b_pix", 32'(vif_b.v_pixel), 32'(q_b.pop_front()));
        end else
            chk("b_pix_blank", 32'(vif_b.v_pixel), 32'd0);
    end

    always @(negedge clk) begin
        if (vif_c.v_de === 1'b1) begin
            chk("c_pix_avail", 32'(q_c.size() != 0), 32'd1);
            if (q_c.size() != 0) chk("c_pix", 32'(vif_c.v_pixel), 32'(q_c.pop_front()));
        end else
            chk("c_pix_blank", 32'(vif_c.v_pixel), 32'd0);
    end

    function automatic logic [20:0] a_status();
        return {vif_a.v_hsync, vif_a.v_vsync, vif_a.v_de, fs_a, busy_a, cnt_a};
    endfunction

    // Two frames from IDLE: frame 1 solid, mode->bars mid frame 1, en dropped on line 1 of frame 2.
    task automatic run_a_seq(input string tag);
        int n = 0;
        logic [20:0] req;
        mode_a = 2'd0;
        repeat (12) q_a.push_back(16'h0080);
        repeat (3) begin
            q_a.push_back(16'h0000); q_a.push_back(16'h0000);
            q_a.push_back(16'h0020); q_a.push_back(16'h0020);
        end
        en_a = 1'b1;
        while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_start"}, 32'(fs_a), 32'd1);
        for (int k = 0; k < 320; k++) begin
            int h = k % 10;
            int v = (k / 10) % 6;
            bit r = (k < 120);
            req = {r && h < 2, r && v < 1, r && h >= 4 && h < 8 && v >= 2 && v < 5,
                   r && (k % 60 == 0), r, r ? 16'(k / 60 + 1) : 16'd2};
            chk({tag, "_status"}, 32'(a_status()), 32'(req));
            if (k == 35) mode_a = 2'd2;
            if (k == 70) en_a = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_queue_empty"}, 32'(q_a.size()), 32'd0);
    endtask

    initial begin
        int n;
        int row_lo [4] = '{0, 0, 255, 255};
        int row_hi [4] = '{255, 255, 0, 0};
        rst_a = 1'b1; en_a = 1'b0; mode_a = 2'd0;
        rst_bc = 1'b1; en_b = 1'b0; mode_b = 2'd1; en_c = 1'b0; mode_c = 2'd3;
        repeat (3) @(negedge clk);
        chk("a_reset_status", 32'(a_status()), 32'd0);
        chk("a_reset_pixel", 32'(vif_a.v_pixel), 32'd0);
        chk("b_reset_hsync", 32'(vif_b.v_hsync), 32'd1);
        chk("b_reset_vsync", 32'(vif_b.v_vsync), 32'd1);
        rst_a = 1'b0; rst_bc = 1'b0;
        repeat (4) @(negedge clk);
        chk("a_idle_status", 32'(a_status()), 32'd0);

        // B: gradient, two pixels per clock
        repeat (3) begin
            q_b.push_back(16'h0100); q_b.push_back(16'h0302);
            q_b.push_back(16'h0504); q_b.push_back(16'h0706);
        end
        en_b = 1'b1;
        n = 0;
        while (fs_b !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("b_start", 32'(fs_b), 32'd1);
        chk("b_hsync_active_low", 32'(vif_b.v_hsync), 32'd0);
        chk("b_vsync_active_low", 32'(vif_b.v_vsync), 32'd0);
        en_b = 1'b0;
        n = 0;
        while (busy_b !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("b_busy_fall_cycle", 32'(n), 32'd60);
        chk("b_frame_cnt", 32'(cnt_b), 32'd1);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);

        // C: checker with 2x2 cells
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                q_c.push_back(16'((y < 2) ? row_lo[x] : row_hi[x]));
        en_c = 1'b1;
        n = 0;
        while (fs_c !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("c_start", 32'(fs_c), 32'd1);
        en_c = 1'b0;
        n = 0;
        while (busy_c !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("c_busy_fall_cycle", 32'(n), 32'd70);
        chk("c_queue_empty", 32'(q_c.size()), 32'd0);

        // A: timing, mode change, clean stop
        run_a_seq("a_run1");

        // A: reset in the middle of an active line (h=5, v=2)
        mode_a = 2'd0;
        q_a.push_back(16'h0080); q_a.push_back(16'h0080);
        en_a = 1'b1;
        n = 0;
        while (fs_a !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("a_rerun_start", 32'(fs_a), 32'd1);
        repeat (25) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_midreset_status", 32'(a_status()), 32'd0);
        chk("a_midreset_queue", 32'(q_a.size()), 32'd0);
        rst_a = 1'b0; en_a = 1'b0;
        repeat (3) @(negedge clk);
        chk("a_post_reset_idle", 32'(a_status()), 32'd0);

        run_a_seq("a_run2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
